// File: rtl/frame_window_reader_if.sv
// Signal bundle between the frame window reader, its window buffer, coefficient ROM
// and the downstream sample sink. The reader side is the master.
interface frame_window_reader_if #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAME_SIZE = 306
);
    localparam int ADDR_W = $clog2(FRAME_SIZE);

    logic                  buf_idle_i;
    logic                  buf_valid_i;
    logic [WIDTH-1:0]      buf_data_i;
    logic                  buf_rd_en_o;
    logic                  start_move_o;
    logic [ADDR_W-1:0]     coef_addr_o;
    logic [COEF_WIDTH-1:0] coef_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [WIDTH-1:0]      out_data_o;
    logic                  out_last_o;
    logic                  frame_done_o;

    modport master (
        input  buf_idle_i,
        input  buf_valid_i,
        input  buf_data_i,
        output buf_rd_en_o,
        output start_move_o,
        output coef_addr_o,
        input  coef_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output out_last_o,
        output frame_done_o
    );

    modport slave (
        output buf_idle_i,
        output buf_valid_i,
        output buf_data_i,
        input  buf_rd_en_o,
        input  start_move_o,
        input  coef_addr_o,
        output coef_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  out_last_o,
        input  frame_done_o
    );
endinterface

// File: rtl/frame_window_reader.sv
// Reads one frame from the window buffer, multiplies each sample by its window
// coefficient (Q-format, rounded and saturated) and streams it out, then requests a hop.
module frame_window_reader #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_window_reader_if.master bus
);
    localparam int IDX_W = $clog2(FRAME_SIZE);
    localparam int CNT_W = $clog2(FRAME_SIZE + 1);
    localparam int P_W   = WIDTH + COEF_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(FRAME_SIZE);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(FRAME_SIZE - 1);
    localparam logic signed [P_W-1:0] RND      = P_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [P_W-1:0] MAXV     = P_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [P_W-1:0] MINV     = P_W'(-(2 ** (WIDTH - 1)));

    localparam logic [2:0] WAIT_FILL = 3'd0;
    localparam logic [2:0] READ      = 3'd1;
    localparam logic [2:0] DRAIN     = 3'd2;
    localparam logic [2:0] MOVE      = 3'd3;
    localparam logic [2:0] WAIT_BUSY = 3'd4;

    function automatic logic signed [P_W-1:0] round_shift(input logic signed [P_W-1:0] p);
        logic signed [P_W-1:0] t;
        t = p + RND;
        return t >>> FRAC_BITS;
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [P_W-1:0] v);
        if (v > MAXV) begin
            return MAXV[WIDTH-1:0];
        end else if (v < MINV) begin
            return MINV[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] count;

    logic stall;
    logic rd_en;
    logic hs;

    logic                         vld_p1;
    logic signed [WIDTH-1:0]      sample_p1;
    logic [IDX_W-1:0]             idx_p1;
    logic                         vld_p2;
    logic signed [WIDTH-1:0]      sample_p2;
    logic [IDX_W-1:0]             idx_p2;
    logic                         adv_q;
    logic signed [COEF_WIDTH-1:0] coef_hold;
    logic signed [COEF_WIDTH-1:0] coef_eff;
    logic signed [P_W-1:0]        prod;
    logic signed [WIDTH-1:0]      res;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    assign stall = out_valid && !bus.out_ready_i;
    assign rd_en = (state == READ) && (count < CNT_MAX) && !stall;
    assign hs    = rd_en && bus.buf_valid_i;

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FILL: if (bus.buf_idle_i) state_nxt = READ;
            READ:      if (count == CNT_MAX) state_nxt = DRAIN;
            DRAIN:     if (!vld_p1 && !vld_p2 && !out_valid) state_nxt = MOVE;
            MOVE:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!bus.buf_idle_i) state_nxt = WAIT_FILL;
            default:   state_nxt = WAIT_FILL;
        endcase
    end

    // The ROM answers one cycle after the address. If the previous edge was a stall,
    // coef_i now belongs to idx_p1 rather than the stage-2 sample, so use the held copy.
    assign coef_eff = adv_q ? $signed(bus.coef_i) : coef_hold;
    assign prod     = P_W'(sample_p2) * P_W'(coef_eff);
    assign res      = saturate(round_shift(prod));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_FILL;
            count     <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            adv_q     <= 1'b0;
            idx_p1    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_FILL && state_nxt == READ) begin
                count <= '0;
            end else if (hs) begin
                count <= count + 1'b1;
            end
            adv_q <= !stall;
            if (!stall) begin
                // stage 1: capture the handshaken sample index
                vld_p1 <= hs;
                if (hs) begin
                    idx_p1 <= count[IDX_W-1:0];
                end
                // stage 2 -> output register
                vld_p2    <= vld_p1;
                out_valid <= vld_p2;
                out_last  <= vld_p2 && (idx_p2 == IDX_LAST);
                if (vld_p2) begin
                    out_data <= res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            if (hs) begin
                sample_p1 <= $signed(bus.buf_data_i);
            end
            sample_p2 <= sample_p1;
            idx_p2    <= idx_p1;
        end
        coef_hold <= coef_eff;
    end

    assign bus.buf_rd_en_o  = rd_en;
    assign bus.start_move_o = (state == MOVE);
    assign bus.coef_addr_o  = idx_p1;
    assign bus.out_valid_o  = out_valid;
    assign bus.out_data_o   = out_data;
    assign bus.out_last_o   = out_last;
    assign bus.frame_done_o = out_valid && bus.out_ready_i && out_last;
endmodule

// File: tb/tb_frame_window_reader.sv
// Directed bench for frame_window_reader: buffer and ROM models, an output monitor,
// and one task per scenario.
module tb_frame_window_reader;
    localparam int WIDTH      = 16;
    localparam int COEF_WIDTH = 16;
    localparam int FRAME_SIZE = 306;
    localparam int FRAC_BITS  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_window_reader_if #(.WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .FRAME_SIZE(FRAME_SIZE)) bus ();

    frame_window_reader #(
        .WIDTH(WIDTH), .FRAME_SIZE(FRAME_SIZE), .COEF_WIDTH(COEF_WIDTH), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic                  idle;
    logic                  valid_const;
    logic                  toggle_en;
    logic                  vphase = 1'b0;
    logic                  ready;
    logic                  data_mode;
    logic [WIDTH-1:0]      data_fixed;
    logic [COEF_WIDTH-1:0] coef_const;
    logic                  rom_mode;
    logic                  ptr_clr;
    int                    rd_ptr = 0;

    int errors = 0;
    int checks = 0;

    always @(negedge clk) if (toggle_en) vphase <= ~vphase;

    assign bus.buf_idle_i  = idle;
    assign bus.buf_valid_i = toggle_en ? vphase : valid_const;
    assign bus.out_ready_i = ready;
    assign bus.buf_data_i  = data_mode ? 16'(100 + rd_ptr) : data_fixed;

    always @(posedge clk) begin
        if (ptr_clr) rd_ptr <= 0;
        else if (bus.buf_rd_en_o && bus.buf_valid_i) rd_ptr <= rd_ptr + 1;
    end

    // ROM: even addresses hold ~1.0, odd addresses 0.5
    always @(posedge clk)
        bus.coef_i <= rom_mode ? (bus.coef_addr_o[0] ? 16'h4000 : 16'h7FFF) : coef_const;

    logic [WIDTH:0]   outq[$];
    int               hsq[$];
    int               cyc = 0;
    int               n_done = 0;
    int               n_move = 0;
    int               last_done_cyc = 0;
    int               last_move_cyc = 0;
    int               stab_err = 0;
    int               rd_stall = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;

    always @(posedge clk) begin
        if (bus.out_valid_o && ready) outq.push_back({bus.out_last_o, bus.out_data_o});
        if (bus.buf_rd_en_o && bus.buf_valid_i) hsq.push_back(cyc);
        if (bus.frame_done_o) begin
            n_done        <= n_done + 1;
            last_done_cyc <= cyc;
        end
        if (bus.start_move_o) begin
            n_move        <= n_move + 1;
            last_move_cyc <= cyc;
        end
        if (prev_stall && (!bus.out_valid_o || bus.out_data_o != prev_data || bus.out_last_o != prev_last))
            stab_err <= stab_err + 1;
        if (bus.buf_rd_en_o && bus.out_valid_o && !ready) rd_stall <= rd_stall + 1;
        prev_stall <= bus.out_valid_o && !ready;
        prev_data  <= bus.out_data_o;
        prev_last  <= bus.out_last_o;
        cyc        <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic logic [WIDTH-1:0] exp_ramp(input int i);
        int d;
        d = 100 + i;
        return (i % 2 == 0) ? 16'(d) : 16'((d + 1) / 2);
    endfunction

    task automatic start_frame();
        @(negedge clk);
        ptr_clr = 1'b1;
        @(negedge clk);
        ptr_clr = 1'b0;
        idle    = 1'b1;
    endtask

    task automatic wait_move(input int base, output bit to);
        int k;
        k = 0;
        while (n_move == base && k < 3000) begin
            @(negedge clk);
            k++;
        end
        to = (n_move == base);
        @(negedge clk);
        idle = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle = 1'b1;
        valid_const = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid_o); end
        checks++; if (bus.buf_rd_en_o !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", bus.buf_rd_en_o); end
        checks++; if (bus.start_move_o !== 1'b0) begin errors++; $display("FAIL rst_start_move: got %b want 0", bus.start_move_o); end
        checks++; if (bus.out_last_o !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last_o); end
        checks++; if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", bus.frame_done_o); end
        checks++; if (bus.out_data_o !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data_o); end
        checks++; if (bus.coef_addr_o !== '0) begin errors++; $display("FAIL rst_coef_addr: got %0d want 0", bus.coef_addr_o); end
        idle = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unity_frame();
        int  qb, db, mb, k, lat, n, bad, lastcnt, lastpos;
        bit  to;
        data_mode = 1'b0; data_fixed = 16'h4000; rom_mode = 1'b0; coef_const = 16'h7FFF;
        valid_const = 1'b1; ready = 1'b1;
        qb = outq.size(); db = n_done; mb = n_move;
        start_frame();
        k = 0;
        while (!(bus.buf_rd_en_o && bus.buf_valid_i) && k < 100) begin @(negedge clk); k++; end
        lat = 0;
        while (!bus.out_valid_o && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3) begin errors++; $display("FAIL unity_latency: got %0d edges want 3", lat); end
        wait_move(mb, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL unity_timeout: got %b want 0", to); end
        n = outq.size() - qb;
        bad = 0; lastcnt = 0; lastpos = -1;
        for (int i = 0; i < n; i++) begin
            if (outq[qb+i][WIDTH-1:0] !== 16'h4000) bad++;
            if (outq[qb+i][WIDTH]) begin lastcnt++; lastpos = i; end
        end
        checks++; if (n !== FRAME_SIZE) begin errors++; $display("FAIL unity_count: got %0d want %0d", n, FRAME_SIZE); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL unity_data: got %0d wrong samples want 0", bad); end
        checks++; if (lastcnt !== 1 || lastpos !== FRAME_SIZE - 1) begin errors++; $display("FAIL unity_last: got %0d flags at %0d want 1 at %0d", lastcnt, lastpos, FRAME_SIZE - 1); end
        checks++; if (n_done - db !== 1) begin errors++; $display("FAIL unity_frame_done: got %0d pulses want 1", n_done - db); end
        checks++; if (n_move - mb !== 1) begin errors++; $display("FAIL unity_start_move: got %0d pulses want 1", n_move - mb); end
        checks++; if (!(last_move_cyc > last_done_cyc)) begin errors++; $display("FAIL unity_move_order: got move %0d done %0d want move after done", last_move_cyc, last_done_cyc); end
    endtask

    task automatic test_saturation_rounding();
        logic [WIDTH-1:0] vd[6] = '{16'h8000, 16'h0001, 16'hFFFF, 16'hC000, 16'h7FFF, 16'h8000};
        logic [WIDTH-1:0] vc[6] = '{16'h8000, 16'h4000, 16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        logic [WIDTH-1:0] ve[6] = '{16'h7FFF, 16'h0001, 16'h0000, 16'hC001, 16'h7FFE, 16'h8001};
        int qb, mb, n, bad;
        logic [WIDTH-1:0] got;
        bit to;
        for (int v = 0; v < 6; v++) begin
            data_mode = 1'b0; data_fixed = vd[v]; rom_mode = 1'b0; coef_const = vc[v];
            valid_const = 1'b1; ready = 1'b1;
            qb = outq.size(); mb = n_move;
            start_frame();
            wait_move(mb, to);
            n = outq.size() - qb;
            bad = 0; got = '0;
            for (int i = 0; i < n; i++) if (outq[qb+i][WIDTH-1:0] !== ve[v]) begin bad++; got = outq[qb+i][WIDTH-1:0]; end
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL arith_timeout[%0d]: got %b want 0", v, to); end
            checks++; if (n !== FRAME_SIZE) begin errors++; $display("FAIL arith_count[%0d]: got %0d want %0d", v, n, FRAME_SIZE); end
            checks++; if (bad !== 0) begin errors++; $display("FAIL arith_value[%0d]: %0d samples like %h want %h", v, bad, got, ve[v]); end
        end
    endtask

    task automatic test_stall();
        int qb, mb, sb, rb, k, n, bad, badl;
        bit to;
        data_mode = 1'b1; rom_mode = 1'b1; valid_const = 1'b1; ready = 1'b1;
        qb = outq.size(); mb = n_move; sb = stab_err; rb = rd_stall;
        start_frame();
        k = 0;
        while (outq.size() - qb < 50 && k < 500) begin @(negedge clk); k++; end
        ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.buf_rd_en_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_rd_en: got rd_en %b valid %b want 0 1", bus.buf_rd_en_o, bus.out_valid_o); end
        repeat (9) @(negedge clk);
        ready = 1'b1;
        wait_move(mb, to);
        n = outq.size() - qb;
        bad = 0; badl = 0;
        for (int i = 0; i < n; i++) begin
            if (outq[qb+i][WIDTH-1:0] !== exp_ramp(i)) bad++;
            if (outq[qb+i][WIDTH] !== (i == FRAME_SIZE - 1)) badl++;
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %b want 0", to); end
        checks++; if (n !== FRAME_SIZE) begin errors++; $display("FAIL stall_count: got %0d want %0d", n, FRAME_SIZE); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order: got %0d wrong samples want 0", bad); end
        checks++; if (badl !== 0) begin errors++; $display("FAIL stall_last: got %0d wrong flags want 0", badl); end
        checks++; if (stab_err - sb !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stab_err - sb); end
        checks++; if (rd_stall - rb !== 0) begin errors++; $display("FAIL stall_read: got %0d reads while stalled want 0", rd_stall - rb); end
    endtask

    task automatic test_bubbles();
        int qb, mb, hb, n, nh, span, bad;
        bit to;
        data_mode = 1'b1; rom_mode = 1'b1; ready = 1'b1; toggle_en = 1'b1;
        qb = outq.size(); mb = n_move; hb = hsq.size();
        start_frame();
        wait_move(mb, to);
        toggle_en = 1'b0;
        n = outq.size() - qb;
        nh = hsq.size() - hb;
        span = (nh > 0) ? hsq[hsq.size()-1] - hsq[hb] : -1;
        bad = 0;
        for (int i = 0; i < n; i++) if (outq[qb+i][WIDTH-1:0] !== exp_ramp(i)) bad++;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bubble_timeout: got %b want 0", to); end
        checks++; if (n !== FRAME_SIZE) begin errors++; $display("FAIL bubble_count: got %0d want %0d", n, FRAME_SIZE); end
        checks++; if (nh !== FRAME_SIZE) begin errors++; $display("FAIL bubble_reads: got %0d want %0d", nh, FRAME_SIZE); end
        checks++; if (span !== 2 * (FRAME_SIZE - 1)) begin errors++; $display("FAIL bubble_span: got %0d want %0d", span, 2 * (FRAME_SIZE - 1)); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bubble_order: got %0d wrong samples want 0", bad); end
    endtask

    task automatic test_reset_midframe();
        int qb, mb, hb, k, n, bad;
        bit to;
        data_mode = 1'b1; rom_mode = 1'b1; valid_const = 1'b1; ready = 1'b1;
        hb = hsq.size();
        start_frame();
        k = 0;
        while (hsq.size() - hb < 100 && k < 500) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 16'h0000) begin errors++; $display("FAIL midrst_out: got valid %b data %h want 0 0000", bus.out_valid_o, bus.out_data_o); end
        checks++; if (bus.coef_addr_o !== '0 || bus.buf_rd_en_o !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got addr %0d rd_en %b want 0 0", bus.coef_addr_o, bus.buf_rd_en_o); end
        idle = 1'b0; ptr_clr = 1'b1;
        @(negedge clk);
        ptr_clr = 1'b0;
        qb = outq.size(); mb = n_move;
        rst = 1'b0;
        @(negedge clk);
        idle = 1'b1;
        k = 0;
        while (!(bus.buf_rd_en_o && bus.buf_valid_i) && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        checks++; if (bus.coef_addr_o !== 9'd0) begin errors++; $display("FAIL midrst_addr0: got %0d want 0", bus.coef_addr_o); end
        @(negedge clk);
        checks++; if (bus.coef_addr_o !== 9'd1) begin errors++; $display("FAIL midrst_addr1: got %0d want 1", bus.coef_addr_o); end
        wait_move(mb, to);
        n = outq.size() - qb;
        bad = 0;
        for (int i = 0; i < n; i++) if (outq[qb+i][WIDTH-1:0] !== exp_ramp(i)) bad++;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %b want 0", to); end
        checks++; if (n !== FRAME_SIZE) begin errors++; $display("FAIL midrst_count: got %0d want %0d", n, FRAME_SIZE); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_order: got %0d wrong samples want 0", bad); end
    endtask

    initial begin
        rst = 1'b1; idle = 1'b0; valid_const = 1'b0; toggle_en = 1'b0; ready = 1'b1;
        data_mode = 1'b0; data_fixed = '0; coef_const = '0; rom_mode = 1'b0; ptr_clr = 1'b1;
        repeat (2) @(negedge clk);
        ptr_clr = 1'b0;
        test_reset();
        test_unity_frame();
        test_saturation_rounding();
        test_stall();
        test_bubbles();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_window_reader.md
FRAME_WINDOW_READER -- requirements
Module: frame_window_reader

Interface
REQ-001 Parameter WIDTH, default 16: sample width, signed two's complement.
REQ-002 Parameter FRAME_SIZE, default 306: samples per frame.
REQ-003 Parameter COEF_WIDTH, default 16: window coefficient width, signed.
REQ-004 Parameter FRAC_BITS, default 15: coefficient fractional bits.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 buf_idle_i  in  1  window buffer has finished filling and is idle.
REQ-008 buf_valid_i  in  1  window buffer read data valid.
REQ-009 buf_data_i  in  WIDTH  window buffer read data (current read position).
REQ-010 buf_rd_en_o  out  1  read strobe; a sample is consumed on each edge where buf_rd_en_o and buf_valid_i are both high.
REQ-011 start_move_o  out  1  one-cycle pulse requesting the buffer to advance one hop.
REQ-012 coef_addr_o  out  $clog2(FRAME_SIZE)  window ROM address.
REQ-013 coef_i  in  COEF_WIDTH  ROM data, valid one cycle after coef_addr_o.
REQ-014 out_valid_o / out_ready_i / out_data_o (WIDTH) / out_last_o  out/in/out/out  windowed sample stream; out_last_o marks sample FRAME_SIZE-1.
REQ-015 frame_done_o  out  1  one-cycle pulse when the last sample of a frame is accepted downstream.

Function
REQ-016 FSM states WAIT_FILL, READ, DRAIN, MOVE, WAIT_BUSY; reset state WAIT_FILL.
REQ-017 WAIT_FILL -> READ when buf_idle_i=1; index counter cleared to 0 on entry to READ.
REQ-018 READ: buf_rd_en_o = (count < FRAME_SIZE) && !stall; stall = out_valid_o && !out_ready_i.
REQ-019 count increments only on handshake (buf_rd_en_o && buf_valid_i); READ -> DRAIN when count reaches FRAME_SIZE.
REQ-020 DRAIN -> MOVE when the pipeline holds no samples and out_valid_o=0.
REQ-021 MOVE: start_move_o=1 for exactly one cycle; MOVE -> WAIT_BUSY unconditionally.
REQ-022 WAIT_BUSY -> WAIT_FILL when buf_idle_i=0; prevents re-reading a stale frame.
REQ-023 Stage 1: on handshake, register sample and index; coef_addr_o = registered index; held constant while stalled.
REQ-024 Stage 2: product = sample * coef_i, full WIDTH+COEF_WIDTH signed; add 2^(FRAC_BITS-1); arithmetic shift right FRAC_BITS; saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-025 Result loads the output register when it is empty or being accepted the same cycle; out_last_o set iff index = FRAME_SIZE-1.
REQ-026 Latency: sample handshake at edge N -> out_valid_o high after edge N+2 absent stall.
REQ-027 Stall freezes all pipeline stages; no sample is dropped or duplicated; out_data_o and out_last_o are stable while out_valid_o && !out_ready_i.
REQ-028 buf_valid_i low mid-frame: no consumption; count holds; bubbles propagate with valid flags cleared.
REQ-029 frame_done_o pulses on the cycle out_valid_o && out_ready_i && out_last_o.
REQ-030 buf_rd_en_o is never high outside READ; start_move_o is never high outside MOVE.
REQ-031 Counter width holds 0..FRAME_SIZE; no wrap; index never exceeds FRAME_SIZE-1.

Reset
REQ-032 rst high at an edge: state WAIT_FILL, count 0, all pipeline valid flags 0.
REQ-033 Outputs under reset: buf_rd_en_o=0, start_move_o=0, out_valid_o=0, out_last_o=0, frame_done_o=0, out_data_o=0, coef_addr_o=0.
REQ-034 Reset mid-frame abandons the frame; after release, the first output is index 0 of the next filled frame.

Verification
REQ-035 buf_idle_i=1, buf_valid_i=1, data=0x4000, coef=0x7FFF, out_ready_i=1 -> 306 outputs of 0x4000, out_last_o on the 306th only, one frame_done_o, then one start_move_o pulse.
REQ-036 data=0x8000, coef=0x8000 (-1 x -1) -> out_data_o saturates to 0x7FFF.
REQ-037 data=0x0001, coef=0x4000 -> 0x0001 (rounded 0.5 up); data=0xFFFF, coef=0x4000 -> 0x0000.
REQ-038 out_ready_i low 10 cycles mid-frame -> buf_rd_en_o low within 1 cycle, output held stable, all 306 indices delivered in order.
REQ-039 buf_valid_i toggling 1/0 each cycle -> 306 samples in order, frame length doubles, no duplicates.
REQ-040 rst asserted at sample 100 -> outputs zero next cycle; after release and buf_idle_i=1, the new frame starts at coef_addr_o=0.
